// File: rtl/pkg_SQImageCache.sv
// rtl/pkg_SQImageCache.sv - squared-integral-image cache word geometry
package pkg_SQImageCache;
    localparam int SQImageDepth = 28;
endpackage

// File: rtl/pkg_integralImageCache.sv
// rtl/pkg_integralImageCache.sv - integral-image cache word geometry
package pkg_integralImageCache;
    localparam int integralImageDepth = 20;
endpackage

// File: rtl/variance_cache_mc.sv
// rtl/variance_cache_mc.sv - multi-slot window corner cache with pipelined variance
//
// Holds NUM_WIN window slots, each with four integral/squared-integral corners
// (A top-left, B top-right, C bottom-left, D bottom-right) and a valid mask.
// A request on a slot computes N*sumSq - sum^2 over that window in a
// three-stage pipeline with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en/wr_win/wr_addr/wr_sum/wr_sq
//                       corner write into slot wr_win, corner wr_addr
//   wr_clr              clear the valid mask of slot wr_win
//   rd_valid/rd_ready   request handshake; rd_win slot, rd_area pixel count
//   out_valid/out_ready result handshake; out_win slot, out_var variance,
//                       out_err set when the slot was incomplete or out of range
module variance_cache_mc #(
    parameter int NUM_WIN      = 4,
    parameter int ADDR_WIDTH   = 2,
    parameter int WORD_SIZE    = pkg_integralImageCache::integralImageDepth,
    parameter int WORD_SIZE_SQ = pkg_SQImageCache::SQImageDepth,
    parameter int AREA_WIDTH   = 10,
    localparam int WIN_W       = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1,
    localparam int VAR_WIDTH   = AREA_WIDTH + WORD_SIZE_SQ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WIN_W-1:0]        wr_win,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [WORD_SIZE-1:0]    wr_sum,
    input  logic [WORD_SIZE_SQ-1:0] wr_sq,
    input  logic                    wr_clr,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [WIN_W-1:0]        rd_win,
    input  logic [AREA_WIDTH-1:0]   rd_area,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIN_W-1:0]        out_win,
    output logic [VAR_WIDTH-1:0]    out_var,
    output logic                    out_err
);

    localparam int CORNERS = 2 ** ADDR_WIDTH;
    localparam logic [WIN_W:0] NUM_WIN_L = (WIN_W + 1)'(NUM_WIN);

    localparam logic [ADDR_WIDTH-1:0] CORNER_A = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] CORNER_B = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CORNER_C = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] CORNER_D = ADDR_WIDTH'(3);

    // Slot index bound check; an extra MSB keeps the compare unsigned and
    // correct even when NUM_WIN is not a power of two.
    function automatic logic win_in_range(input logic [WIN_W-1:0] w);
        return {1'b0, w} < NUM_WIN_L;
    endfunction

    // ------------------------------------------------------------------
    // Corner storage
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0]    sum_mem    [NUM_WIN][CORNERS];
    logic [WORD_SIZE_SQ-1:0] sq_mem     [NUM_WIN][CORNERS];
    logic [CORNERS-1:0]      valid_mask [NUM_WIN];

    logic wr_ok;
    assign wr_ok = win_in_range(wr_win);

    // Corner data is qualified by the valid mask, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            sum_mem[wr_win][wr_addr] <= wr_sum;
            sq_mem[wr_win][wr_addr]  <= wr_sq;
        end
    end

    // A clear beats a simultaneous write for the mask; the data above is
    // still written so a following write completes the new window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                valid_mask[i] <= '0;
            end
        end else if (wr_ok) begin
            if (wr_clr) begin
                valid_mask[wr_win] <= '0;
            end else if (wr_en) begin
                valid_mask[wr_win][wr_addr] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic stall;
    logic advance;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign rd_ready = !stall;
    assign accept   = rd_valid && rd_ready;

    // ------------------------------------------------------------------
    // Read combine (reads the registered storage, so a write landing on
    // the same edge is not seen by this request)
    // ------------------------------------------------------------------
    logic                    rd_ok;
    logic                    rd_complete;
    logic [WORD_SIZE-1:0]    rd_sum;
    logic [WORD_SIZE_SQ-1:0] rd_sq;

    assign rd_ok = win_in_range(rd_win);

    always_comb begin
        rd_sum      = '0;
        rd_sq       = '0;
        rd_complete = 1'b0;
        if (rd_ok) begin
            rd_sum = sum_mem[rd_win][CORNER_D] - sum_mem[rd_win][CORNER_B]
                   - sum_mem[rd_win][CORNER_C] + sum_mem[rd_win][CORNER_A];
            rd_sq  = sq_mem[rd_win][CORNER_D] - sq_mem[rd_win][CORNER_B]
                   - sq_mem[rd_win][CORNER_C] + sq_mem[rd_win][CORNER_A];
            rd_complete = &valid_mask[rd_win];
        end
    end

    // ------------------------------------------------------------------
    // S1: window sums
    // ------------------------------------------------------------------
    logic                    s1_valid;
    logic [WIN_W-1:0]        s1_win;
    logic [AREA_WIDTH-1:0]   s1_area;
    logic                    s1_ok;
    logic [WORD_SIZE-1:0]    s1_sum;
    logic [WORD_SIZE_SQ-1:0] s1_sq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_win   <= '0;
            s1_area  <= '0;
            s1_ok    <= 1'b0;
            s1_sum   <= '0;
            s1_sq    <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_win  <= rd_win;
                s1_area <= rd_area;
                s1_ok   <= rd_complete;
                s1_sum  <= rd_sum;
                s1_sq   <= rd_sq;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: products
    // ------------------------------------------------------------------
    logic [VAR_WIDTH-1:0]   p_next;
    logic [2*WORD_SIZE-1:0] q_full;

    assign p_next = VAR_WIDTH'(s1_area) * VAR_WIDTH'(s1_sq);
    assign q_full = (2 * WORD_SIZE)'(s1_sum) * (2 * WORD_SIZE)'(s1_sum);

    logic                 s2_valid;
    logic [WIN_W-1:0]     s2_win;
    logic                 s2_ok;
    logic [VAR_WIDTH-1:0] s2_p;
    logic [VAR_WIDTH-1:0] s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_win   <= '0;
            s2_ok    <= 1'b0;
            s2_p     <= '0;
            s2_q     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_win <= s1_win;
                s2_ok  <= s1_ok;
                s2_p   <= p_next;
                // sum^2 is resized to the variance width (extend or truncate).
                s2_q   <= VAR_WIDTH'(q_full);
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: clamped difference, output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_win   <= '0;
            out_var   <= '0;
            out_err   <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_win <= s2_win;
                out_err <= !s2_ok;
                // Rounding in the integral images can make P < Q; clamp to 0.
                if (s2_ok && (s2_p >= s2_q)) begin
                    out_var <= s2_p - s2_q;
                end else begin
                    out_var <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_variance_cache_mc.sv
// tb/tb_variance_cache_mc.sv - directed self-checking bench for variance_cache_mc
module tb_variance_cache_mc;

    localparam int NUM_WIN      = 4;
    localparam int ADDR_WIDTH   = 2;
    localparam int WORD_SIZE    = 20;
    localparam int WORD_SIZE_SQ = 28;
    localparam int AREA_WIDTH   = 10;
    localparam int WIN_W        = 2;
    localparam int VAR_WIDTH    = 38;

    logic                    clk;
    logic                    rst;
    logic                    wr_en;
    logic [WIN_W-1:0]        wr_win;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [WORD_SIZE-1:0]    wr_sum;
    logic [WORD_SIZE_SQ-1:0] wr_sq;
    logic                    wr_clr;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [WIN_W-1:0]        rd_win;
    logic [AREA_WIDTH-1:0]   rd_area;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIN_W-1:0]        out_win;
    logic [VAR_WIDTH-1:0]    out_var;
    logic                    out_err;

    variance_cache_mc #(
        .NUM_WIN      (NUM_WIN),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .WORD_SIZE    (WORD_SIZE),
        .WORD_SIZE_SQ (WORD_SIZE_SQ),
        .AREA_WIDTH   (AREA_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_win    (wr_win),
        .wr_addr   (wr_addr),
        .wr_sum    (wr_sum),
        .wr_sq     (wr_sq),
        .wr_clr    (wr_clr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_win    (rd_win),
        .rd_area   (rd_area),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .out_var   (out_var),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_corner(input int win, input int addr, input int s, input int q);
        wr_en   = 1'b1;
        wr_win  = WIN_W'(win);
        wr_addr = ADDR_WIDTH'(addr);
        wr_sum  = WORD_SIZE'(s);
        wr_sq   = WORD_SIZE_SQ'(q);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic write_slot(input int win, input int sa, input int sb, input int sc, input int sd,
                              input int qa, input int qb, input int qc, input int qd);
        wr_corner(win, 0, sa, qa);
        wr_corner(win, 1, sb, qb);
        wr_corner(win, 2, sc, qc);
        wr_corner(win, 3, sd, qd);
    endtask

    task automatic request(input int win, input int area);
        rd_valid = 1'b1;
        rd_win   = WIN_W'(win);
        rd_area  = AREA_WIDTH'(area);
        tick();
        rd_valid = 1'b0;
    endtask

    // Single request with exact-latency check of the result.
    task automatic expect_result(input string tag, input int win, input int area,
                                 input int exp_var, input int exp_err);
        request(win, area);
        tick();
        check({tag, "_early"}, 64'(out_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_win"},   64'(out_win),   64'(win));
        check({tag, "_var"},   64'(out_var),   64'(exp_var));
        check({tag, "_err"},   64'(out_err),   64'(exp_err));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_win = '0; wr_addr = '0; wr_sum = '0; wr_sq = '0;
        wr_clr = 1'b0; rd_valid = 1'b0; rd_win = '0; rd_area = '0; out_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_err",   64'(out_err),   64'd0);
        check("rst_out_var",   64'(out_var),   64'd0);
        check("rst_out_win",   64'(out_win),   64'd0);
        rst = 1'b0;
        tick();
        check("rst_rd_ready",  64'(rd_ready),  64'd1);

        // Basic: sum=50-10-20+0=20, sq=300 -> 4*300-400 = 800
        write_slot(1, 0, 10, 20, 50, 0, 100, 200, 600);
        expect_result("basic", 1, 4, 800, 0);

        // Clamp: sq=50 -> 200-400 < 0 -> 0
        write_slot(2, 0, 10, 20, 50, 0, 0, 0, 50);
        expect_result("clamp", 2, 4, 0, 0);

        // Incomplete, then completed, then cleared
        wr_corner(3, 0, 0, 0);
        wr_corner(3, 1, 10, 100);
        wr_corner(3, 2, 20, 200);
        expect_result("incomplete", 3, 4, 0, 1);
        wr_corner(3, 3, 50, 600);
        expect_result("completed", 3, 4, 800, 0);
        wr_clr = 1'b1; wr_win = 2'd3;
        tick();
        wr_clr = 1'b0;
        expect_result("cleared", 3, 4, 0, 1);

        // Backpressure: slot0 -> sum 8, sq 20 -> 80-64 = 16; slot1 -> 800;
        // slot2 rewritten -> sum 20, sq 200 -> 800-400 = 400
        write_slot(0, 0, 0, 0, 8, 0, 0, 0, 20);
        write_slot(2, 0, 10, 20, 50, 0, 0, 0, 200);
        tick(); tick(); tick();
        out_ready = 1'b0;
        rd_valid = 1'b1; rd_area = 10'd4;
        rd_win = 2'd0; tick();
        rd_win = 2'd1; tick();
        rd_win = 2'd2; tick();
        rd_valid = 1'b0;
        begin
            int unstable = 0;
            for (int i = 0; i < 5; i++) begin
                if (rd_ready !== 1'b0 || out_valid !== 1'b1 || out_win !== 2'd0 ||
                    out_var !== 38'd16 || out_err !== 1'b0) unstable++;
                tick();
            end
            check("bp_stall_stable", 64'(unstable), 64'd0);
        end
        check("bp_r0_var", 64'(out_var), 64'd16);
        out_ready = 1'b1;
        #1;
        check("bp_ready_released", 64'(rd_ready), 64'd1);
        tick();
        check("bp_r1_valid", 64'(out_valid), 64'd1);
        check("bp_r1_win",   64'(out_win),   64'd1);
        check("bp_r1_var",   64'(out_var),   64'd800);
        tick();
        check("bp_r2_valid", 64'(out_valid), 64'd1);
        check("bp_r2_win",   64'(out_win),   64'd2);
        check("bp_r2_var",   64'(out_var),   64'd400);
        tick();
        check("bp_drained",  64'(out_valid), 64'd0);

        // Same-cycle hazard: D sum 50 -> 60 while slot1 is requested.
        // Old: 800. New: sum 30 -> 1200-900 = 300.
        rd_valid = 1'b1; rd_win = 2'd1; rd_area = 10'd4;
        wr_en = 1'b1; wr_win = 2'd1; wr_addr = 2'd3; wr_sum = 20'd60; wr_sq = 28'd600;
        tick();
        wr_en = 1'b0;
        tick();
        rd_valid = 1'b0;
        tick();
        check("hazard_old_var", 64'(out_var), 64'd800);
        check("hazard_old_vld", 64'(out_valid), 64'd1);
        tick();
        check("hazard_new_var", 64'(out_var), 64'd300);
        check("hazard_new_vld", 64'(out_valid), 64'd1);
        tick();

        // Reset mid-operation with requests in flight
        rd_valid = 1'b1; rd_area = 10'd4;
        rd_win = 2'd0; tick();
        rd_win = 2'd1; tick();
        rd_win = 2'd0; tick();
        rd_valid = 1'b0;
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (out_valid !== 1'b0) seen++;
            end
            check("mid_no_results", 64'(seen), 64'd0);
        end
        expect_result("post_rst", 1, 4, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/variance_cache_mc.md
VARIANCE_CACHE_MC -- requirements
Module: variance_cache_mc

Interface
REQ-001 SHALL have parameter NUM_WIN, default 4: number of independent window slots.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2: corner address width, giving 4 corners per slot.
REQ-003 SHALL have parameter WORD_SIZE, default pkg_integralImageCache::integralImageDepth: width of an integral-image corner.
REQ-004 SHALL have parameter WORD_SIZE_SQ, default pkg_SQImageCache::SQImageDepth: width of a squared-integral corner.
REQ-005 SHALL have parameter AREA_WIDTH, default 10: width of the window pixel count.
REQ-006 SHALL derive the window-index width WIN_W as clog2(NUM_WIN), minimum 1.
REQ-007 SHALL derive the variance width VAR_WIDTH as AREA_WIDTH+WORD_SIZE_SQ.
REQ-008 SHALL have one clock; reset is asynchronous and active-high: clk and rst.
REQ-009 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  corner write strobe
- wr_win  in  WIN_W  slot written
- wr_addr  in  ADDR_WIDTH  corner: 0=A top-left, 1=B top-right, 2=C bottom-left, 3=D bottom-right
- wr_sum  in  WORD_SIZE  integral corner value
- wr_sq  in  WORD_SIZE_SQ  squared-integral corner value
- wr_clr  in  1  clear the valid bits of slot wr_win
- rd_valid  in  1  variance request
- rd_ready  out  1  request accepted when rd_valid and rd_ready are both high
- rd_win  in  WIN_W  requested slot
- rd_area  in  AREA_WIDTH  pixel count N
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_win  out  WIN_W  slot of the result
- out_var  out  VAR_WIDTH  N*sumSq - sum^2
- out_err  out  1  requested slot was incomplete

Function
REQ-010 Storage SHALL be NUM_WIN x 4 corner pairs (sum, sq) plus a 4-bit valid mask per slot.
REQ-011 On wr_en, the addressed corner SHALL be written and its valid bit set at the next edge.
REQ-012 On wr_clr, the valid mask of slot wr_win SHALL be cleared; if wr_en is also high, wr_clr SHALL win for the mask and the data SHALL still be written.
REQ-013 A slot SHALL be complete when all 4 valid bits are set.
REQ-014 Writes SHALL NOT be blocked by pipeline state.
REQ-015 Pipeline stage S1 (the accept cycle) SHALL latch:
- win and area
- complete flag
- sum = D-B-C+A modulo 2^WORD_SIZE
- sq = D-B-C+A modulo 2^WORD_SIZE_SQ
REQ-016 S1 SHALL use storage contents as they stand before any same-cycle write, so a same-slot write does not affect that request.
REQ-017 Stage S2 SHALL compute P = area*sq (VAR_WIDTH bits) and Q = sum*sum (2*WORD_SIZE bits, zero-extended or truncated to VAR_WIDTH); all arithmetic is unsigned.
REQ-018 Stage S3 SHALL register out_var = P-Q when P>=Q, else 0 (clamp).
REQ-019 For an incomplete slot, S3 SHALL register out_var=0 and out_err=1; otherwise out_err=0.
REQ-020 Latency SHALL be exactly 3 cycles from accept to out_valid with no stall.
REQ-021 Throughput SHALL be one request per cycle.
REQ-022 Results SHALL leave in request order.
REQ-023 Stall SHALL be out_valid and not out_ready.
REQ-024 During a stall, all stages SHALL hold, out_* SHALL be held stable, and rd_ready SHALL be 0.
REQ-025 Otherwise rd_ready SHALL be 1.
REQ-026 Bubbles SHALL propagate as invalid stages; no result SHALL be lost or duplicated.
REQ-027 rd_win or wr_win >= NUM_WIN SHALL be ignored for writes, and SHALL return out_err=1, out_var=0 for reads.

Reset
REQ-028 On rst, asynchronously:
- all valid masks and pipeline valid bits cleared
- out_valid=0, out_err=0, out_var=0, out_win=0
- rd_ready=1 once rst deasserts
REQ-029 Corner data SHALL need no reset.
REQ-030 Requests in flight at reset SHALL be discarded with no output.

Verification
REQ-031 Parameters for all scenarios: NUM_WIN=4, WORD_SIZE=20, WORD_SIZE_SQ=28, AREA_WIDTH=10.
REQ-032 Basic: slot1 sums A,B,C,D=0,10,20,50; sq=0,100,200,600; request area=4 -> 3 cycles later out_valid=1, out_win=1, out_var=800, out_err=0.
REQ-033 Clamp: same sums, sq=0,0,0,50, area=4 -> out_var=0, out_err=0.
REQ-034 Incomplete/clear: write corners 0-2 only, request -> out_err=1, out_var=0; complete the slot, wr_clr it, request -> out_err=1.
REQ-035 Backpressure: 3 back-to-back requests (slots 0,1,2) with out_ready low for 5 cycles -> rd_ready=0 during stall, out_* stable, then results in order 0,1,2 with none dropped.
REQ-036 Same-cycle hazard: request slot1 while writing D=60 to slot1 -> result uses D=50 (800); the next request uses D=60.
REQ-037 Reset mid-operation: assert rst with 2 requests in flight -> out_valid=0 immediately, no further results; a later request to slot1 -> out_err=1.
